// File: rtl/cpu_axi_pkg.sv
// Shared types and AXI/CPU encodings for the CPU-to-AXI single-beat bridge.
package cpu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] AXI_OKAY       = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [2:0] CORE_TYPE_WORD = 3'd0;
    localparam logic [2:0] CORE_TYPE_HALF = 3'd1;
    localparam logic [2:0] CORE_TYPE_BYTE = 3'd2;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_OKAY;
    endfunction

endpackage

// File: rtl/wstrb_gen.sv
// Maps CPU access size and low address bits to AXI transfer size and write strobe.
module wstrb_gen
    import cpu_axi_pkg::*;
#(
    parameter int STRB_W = 4
) (
    input  logic [2:0]        i_core_type,
    input  logic [1:0]        i_addr_lo,
    output logic [2:0]        o_size,
    output logic [STRB_W-1:0] o_wstrb
);

    localparam logic [STRB_W-1:0] HALF_BASE = STRB_W'(2'b11);
    localparam logic [STRB_W-1:0] BYTE_BASE = STRB_W'(1'b1);

    // Halfword lanes are aligned on addr[1]; addr[0] is deliberately ignored.
    always_comb begin
        o_size  = SIZE_WORD;
        o_wstrb = '1;
        case (i_core_type)
            CORE_TYPE_HALF: begin
                o_size  = SIZE_HALF;
                o_wstrb = HALF_BASE << {i_addr_lo[1], 1'b0};
            end
            CORE_TYPE_BYTE: begin
                o_size  = SIZE_BYTE;
                o_wstrb = BYTE_BASE << i_addr_lo;
            end
            default: begin
                o_size  = SIZE_WORD;
                o_wstrb = '1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_axi_master.sv
// Bridges one CPU request/stall port to a single-beat AXI4 master (LEN=0, INCR).
module cpu_axi_master
    import cpu_axi_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 32,
    parameter int               ID_W      = 4,
    parameter logic [ID_W-1:0]  MASTER_ID = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // CPU side
    input  logic                  i_req_read,
    input  logic                  i_req_write,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [2:0]            i_req_core_type,
    input  logic [DATA_W-1:0]     i_req_wdata,
    output logic [DATA_W-1:0]     o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_stall,
    // AW channel
    output logic [ID_W-1:0]       o_awid,
    output logic [ADDR_W-1:0]     o_awaddr,
    output logic [7:0]            o_awlen,
    output logic [2:0]            o_awsize,
    output logic [1:0]            o_awburst,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    // W channel
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W/8-1:0]   o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    // B channel
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    // AR channel
    output logic [ID_W-1:0]       o_arid,
    output logic [ADDR_W-1:0]     o_araddr,
    output logic [7:0]            o_arlen,
    output logic [2:0]            o_arsize,
    output logic [1:0]            o_arburst,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    // R channel
    input  logic [DATA_W-1:0]     i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    localparam int STRB_W = DATA_W / 8;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [2:0]            r_size;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [DATA_W-1:0]     r_resp_rdata;
    logic                  r_resp_err;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic [2:0]            w_size;
    logic [STRB_W-1:0]     w_wstrb;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_done_now;
    logic                  w_w_done_now;
    logic                  w_req_any;

    wstrb_gen #(
        .STRB_W (STRB_W)
    ) u_wstrb_gen (
        .i_core_type (i_req_core_type),
        .i_addr_lo   (i_req_addr[1:0]),
        .o_size      (w_size),
        .o_wstrb     (w_wstrb)
    );

    assign w_req_any     = i_req_read | i_req_write;
    assign w_aw_hs       = r_awvalid & i_awready;
    assign w_w_hs        = r_wvalid & i_wready;
    assign w_aw_done_now = r_aw_done | w_aw_hs;
    assign w_w_done_now  = r_w_done  | w_w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_addr  <= i_req_addr;
                        r_size  <= w_size;
                        r_wdata <= i_req_wdata;
                        r_wstrb <= w_wstrb;
                    end
                    // A simultaneous read is dropped: the write takes priority.
                    if (i_req_write) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= ST_AW_W;
                    end else if (i_req_read) begin
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (i_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (i_rvalid) begin
                        r_rready     <= 1'b0;
                        r_resp_rdata <= i_rdata;
                        r_resp_err   <= resp_is_err(i_rresp);
                        r_state      <= ST_DONE;
                    end
                end
                ST_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done_now && w_w_done_now) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (i_bvalid) begin
                        r_bready   <= 1'b0;
                        r_resp_err <= resp_is_err(i_bresp);
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_resp_err <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is released while reset is asserted so a held request cannot freeze the CPU.
    assign o_stall = rst_n & (((r_state == ST_IDLE) & w_req_any) |
                              ((r_state != ST_IDLE) & (r_state != ST_DONE)));

    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    assign o_awid    = MASTER_ID;
    assign o_awaddr  = r_addr;
    assign o_awlen   = AXI_LEN_SINGLE;
    assign o_awsize  = r_size;
    assign o_awburst = AXI_BURST_INCR;
    assign o_awvalid = r_awvalid;

    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_wlast   = r_wvalid;
    assign o_wvalid  = r_wvalid;

    assign o_bready  = r_bready;

    assign o_arid    = MASTER_ID;
    assign o_araddr  = r_addr;
    assign o_arlen   = AXI_LEN_SINGLE;
    assign o_arsize  = r_size;
    assign o_arburst = AXI_BURST_INCR;
    assign o_arvalid = r_arvalid;

    assign o_rready  = r_rready;

    rlast_on_beat: assert property (@(posedge clk) disable iff (!rst_n)
        (i_rvalid && r_rready) |-> i_rlast);

endmodule
